// File: rtl/uart_pkg.sv
// Shared UART constants: FIFO defaults and serial frame layout.
package uart_pkg;

  localparam int unsigned FIFO_DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH      = 8;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_STOP_BITS  = 1;
  localparam int unsigned UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  // Serial frame, LSB shifted out first (start bit).
  typedef struct packed {
    logic                      stop;
    logic [UART_DATA_BITS-1:0] data;
    logic                      start;
  } uart_frame_t;

  function automatic uart_frame_t uart_make_frame(input logic [UART_DATA_BITS-1:0] data);
    uart_frame_t f;
    f.stop  = UART_STOP_BIT;
    f.data  = data;
    f.start = UART_START_BIT;
    return f;
  endfunction

endpackage

// File: rtl/pulse_gen.sv
// Rising-edge detector: one-cycle pulse when LVL_SIG goes from low to high.
module pulse_gen (
  input  logic CLK,
  input  logic RST,
  input  logic LVL_SIG,
  output logic PULSE_SIG
);

  logic r_lvl_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lvl_q <= 1'b0;
    end else begin
      r_lvl_q <= LVL_SIG;
    end
  end

  assign PULSE_SIG = LVL_SIG & ~r_lvl_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Show-ahead transmit FIFO feeding a UART transmitter; the transmitter's BUSY
// rising edge consumes the head entry. DEPTH must be a power of two, >= 2.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WR_EN,
  input  logic [DATA_W-1:0]        WR_DATA,
  input  logic                     BUSY,
  output logic [DATA_W-1:0]        RD_DATA,
  output logic                     F_EMPTY,
  output logic                     F_FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic              r_overflow;

  logic              w_busy_rise;
  logic              w_empty;
  logic              w_full;
  logic              w_wr_accept;
  logic              w_pop;

  pulse_gen u_busy_edge (
    .CLK       (CLK),
    .RST       (RST),
    .LVL_SIG   (BUSY),
    .PULSE_SIG (w_busy_rise)
  );

  // Extra wrap bit distinguishes full from empty when indices match.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_wr_accept = WR_EN & ~w_full;
  assign w_pop       = w_busy_rise & ~w_empty;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (WR_EN && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Unreset storage so it maps onto distributed RAM.
  always_ff @(posedge CLK) begin
    if (w_wr_accept && !RST) begin
      r_mem[r_wr_ptr[AW-1:0]] <= WR_DATA;
    end
  end

  assign RD_DATA  = r_mem[r_rd_ptr[AW-1:0]];
  assign F_EMPTY  = w_empty;
  assign F_FULL   = w_full;
  assign COUNT    = r_wr_ptr - r_rd_ptr;
  assign OVERFLOW = r_overflow;

endmodule
